// File: rtl/uart_word_loader_if.sv
// Bundles the byte stream from rx_uart and the word-write bus towards INSTmem.
// The loader takes the slave side; whoever feeds bytes and watches the memory bus takes the master side.
interface uart_word_loader_if #(
  parameter int NB_DATA = 32,
  parameter int N_BITS  = 8,
  parameter int ADDR_W  = 7
);
  logic                start;
  logic                rx_done_tick;
  logic [N_BITS-1:0]   rx_data;
  logic                mem_wr_en;
  logic [ADDR_W-1:0]   mem_addr;
  logic [NB_DATA-1:0]  mem_data;
  logic [ADDR_W:0]     word_count;
  logic                finish_rcv;
  logic                overflow;
  logic                frame_err;
  logic [2:0]          state_dbg;

  // rx_data is qualified only by rx_done_tick (1-cycle pulse, no backpressure);
  // mem_addr/mem_data are qualified only by mem_wr_en and are held otherwise.
  modport slave (
    input  start, rx_done_tick, rx_data,
    output mem_wr_en, mem_addr, mem_data, word_count,
           finish_rcv, overflow, frame_err, state_dbg
  );

  modport master (
    output start, rx_done_tick, rx_data,
    input  mem_wr_en, mem_addr, mem_data, word_count,
           finish_rcv, overflow, frame_err, state_dbg
  );
endinterface

// File: rtl/uart_word_loader.sv
// Packs UART bytes into NB_DATA-bit words and writes them to consecutive INSTmem
// addresses, stopping on a halt word or when memory is full.
module uart_word_loader #(
  parameter int                 NB_DATA     = 32,
  parameter int                 N_BITS      = 8,
  parameter int                 ADDR_W      = 7,
  parameter bit                 LITTLE_END  = 1'b0,
  parameter logic [NB_DATA-1:0] HALT_WORD   = 32'hFFFF_FFFF,
  parameter int                 TIMEOUT_CYC = 0
) (
  input  logic               clock,
  input  logic               reset,
  uart_word_loader_if.slave  bus
);
  localparam int BPW = NB_DATA / N_BITS;
  localparam int BW  = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int TW  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLLECT = 3'd1,
    S_WRITE   = 3'd2,
    S_DONE    = 3'd3,
    S_FULL    = 3'd4
  } state_t;

  state_t              state, state_nx;
  logic [NB_DATA-1:0]  word_q, word_nx, mem_data_q;
  logic [ADDR_W-1:0]   ptr_q, mem_addr_q;
  logic [ADDR_W:0]     wcnt_q;
  logic [BW-1:0]       bcnt_q, idx;
  logic [TW-1:0]       tcnt_q;
  logic                ovf_q, ferr_q;
  logic                tick, halt_hit, last_addr, last_byte, accept, timeout_hit;

  // Byte-acceptance decode shared by the FSM and the datapath.
  always_comb begin
    tick        = bus.rx_done_tick && !bus.start;
    halt_hit    = (state == S_WRITE) && (mem_data_q == HALT_WORD);
    last_addr   = (state == S_WRITE) && (mem_addr_q == '1);
    idx         = (state == S_WRITE) ? '0 : bcnt_q;
    last_byte   = (idx == BW'(BPW - 1));
    accept      = tick && ((state == S_IDLE) || (state == S_COLLECT) ||
                           ((state == S_WRITE) && !halt_hit && !last_addr));
    timeout_hit = (TIMEOUT_CYC > 0) && (state == S_COLLECT) && !bus.rx_done_tick &&
                  !bus.start && (tcnt_q == TW'(TIMEOUT_CYC - 1));
    word_nx     = word_q;
    if (LITTLE_END) word_nx[idx*N_BITS +: N_BITS] = bus.rx_data;
    else            word_nx = (word_q << N_BITS) | NB_DATA'(bus.rx_data);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (bus.start) begin
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_COLLECT: begin
          if (accept)           state_nx = last_byte ? S_WRITE : S_COLLECT;
          else if (timeout_hit) state_nx = S_IDLE;
        end
        // The halt word is written before stopping, and it wins over a full memory.
        S_WRITE: begin
          if (halt_hit)       state_nx = S_DONE;
          else if (last_addr) state_nx = S_FULL;
          else if (accept)    state_nx = last_byte ? S_WRITE : S_COLLECT;
          else                state_nx = S_IDLE;
        end
        default: state_nx = state;
      endcase
    end
  end

  always_comb begin
    bus.mem_wr_en  = (state == S_WRITE);
    bus.finish_rcv = (state == S_DONE) || (state == S_FULL);
    bus.mem_addr   = mem_addr_q;
    bus.mem_data   = mem_data_q;
    bus.word_count = wcnt_q;
    bus.overflow   = ovf_q;
    bus.frame_err  = ferr_q;
    bus.state_dbg  = state;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      word_q     <= '0;
      mem_data_q <= '0;
      mem_addr_q <= '0;
      ptr_q      <= '0;
      wcnt_q     <= '0;
      bcnt_q     <= '0;
      tcnt_q     <= '0;
      ovf_q      <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      ferr_q <= timeout_hit;
      if (bus.start) begin
        word_q <= '0;
        ptr_q  <= '0;
        wcnt_q <= '0;
        bcnt_q <= '0;
        tcnt_q <= '0;
        ovf_q  <= 1'b0;
      end else begin
        if (state == S_WRITE) begin
          ptr_q  <= ptr_q + 1'b1;
          wcnt_q <= wcnt_q + 1'b1;
          bcnt_q <= '0;
        end
        // A completed word is captured into the output registers so the bus holds it.
        if (accept) begin
          word_q <= word_nx;
          bcnt_q <= last_byte ? '0 : idx + 1'b1;
          if (last_byte) begin
            mem_data_q <= word_nx;
            mem_addr_q <= (state == S_WRITE) ? ptr_q + 1'b1 : ptr_q;
          end
        end else if (timeout_hit) begin
          word_q <= '0;
          bcnt_q <= '0;
        end
        if (tick && ((state == S_FULL) || ((state == S_WRITE) && !halt_hit && last_addr)))
          ovf_q <= 1'b1;
        if (bus.rx_done_tick || (state != S_COLLECT) || timeout_hit) tcnt_q <= '0;
        else                                                       tcnt_q <= tcnt_q + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_uart_word_loader.sv
// Bench for uart_word_loader: one big-endian 128-word instance with a 20-clock
// timeout, one little-endian 4-word instance, both against a word-level model.
module tb_uart_word_loader;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clock = ~clock;

  uart_word_loader_if #(.NB_DATA(32), .N_BITS(8), .ADDR_W(7)) if0 ();
  uart_word_loader_if #(.NB_DATA(32), .N_BITS(8), .ADDR_W(2)) if1 ();

  uart_word_loader #(.NB_DATA(32), .N_BITS(8), .ADDR_W(7), .LITTLE_END(1'b0),
                     .HALT_WORD(32'hFFFF_FFFF), .TIMEOUT_CYC(20))
    u0 (.clock(clock), .reset(reset), .bus(if0));
  uart_word_loader #(.NB_DATA(32), .N_BITS(8), .ADDR_W(2), .LITTLE_END(1'b1),
                     .HALT_WORD(32'hFFFF_FFFF), .TIMEOUT_CYC(0))
    u1 (.clock(clock), .reset(reset), .bus(if1));

  // Word-level reference: bytes are collected in groups of four and each group
  // becomes one expected {addr, data} write until a halt word or full memory.
  logic [38:0] exp_q0[$];
  logic [38:0] exp_q1[$];
  logic [7:0]  m_b[2][4];
  int          m_n[2], m_ptr[2], m_cnt[2];
  bit          m_done[2], m_full[2], m_ovf[2];
  int          depth[2] = '{128, 4};
  bit          le[2]    = '{1'b0, 1'b1};

  function automatic void model_start(input int d);
    m_n[d] = 0; m_ptr[d] = 0; m_cnt[d] = 0;
    m_done[d] = 1'b0; m_full[d] = 1'b0; m_ovf[d] = 1'b0;
  endfunction

  function automatic void model_byte(input int d, input logic [7:0] b);
    logic [31:0] w;
    if (m_done[d] || m_full[d]) begin
      if (m_full[d]) m_ovf[d] = 1'b1;
      return;
    end
    m_b[d][m_n[d]] = b;
    m_n[d]++;
    if (m_n[d] == 4) begin
      w = 32'h0;
      for (int k = 0; k < 4; k++)
        w = w | (32'(m_b[d][k]) << (le[d] ? 8*k : 8*(3-k)));
      if (d == 0) exp_q0.push_back({7'(m_ptr[d]), w});
      else        exp_q1.push_back({7'(m_ptr[d]), w});
      m_ptr[d]++;
      m_cnt[d]++;
      m_n[d] = 0;
      if (w == 32'hFFFF_FFFF)      m_done[d] = 1'b1;
      else if (m_ptr[d] == depth[d]) m_full[d] = 1'b1;
    end
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag, input logic we, input logic [6:0] a,
                            input logic [31:0] dt, input logic [7:0] wc,
                            input logic fin, input logic ovf, input logic fe);
    chk({tag, "_wr_en"}, 64'(we), 64'd0);
    chk({tag, "_addr"},  64'(a),  64'd0);
    chk({tag, "_data"},  64'(dt), 64'd0);
    chk({tag, "_wc"},    64'(wc), 64'd0);
    chk({tag, "_fin"},   64'(fin), 64'd0);
    chk({tag, "_ovf"},   64'(ovf), 64'd0);
    chk({tag, "_ferr"},  64'(fe), 64'd0);
  endtask

  // Called at a falling edge; the byte is sampled on the following rising edge.
  task automatic send(input int d, input logic [7:0] b, input int gap);
    model_byte(d, b);
    if (d == 0) begin if0.rx_done_tick = 1'b1; if0.rx_data = b; end
    else        begin if1.rx_done_tick = 1'b1; if1.rx_data = b; end
    @(negedge clock);
    if0.rx_done_tick = 1'b0;
    if1.rx_done_tick = 1'b0;
    repeat (gap) @(negedge clock);
  endtask

  task automatic pulse_start(input int d);
    if (d == 0) if0.start = 1'b1; else if1.start = 1'b1;
    @(negedge clock);
    if0.start = 1'b0;
    if1.start = 1'b0;
    model_start(d);
  endtask

  task automatic send_word(input int d, input int max_gap);
    send(d, 8'($urandom_range(0, 254)), $urandom_range(0, max_gap));
    for (int k = 1; k < 4; k++) send(d, 8'($urandom_range(0, 255)), $urandom_range(0, max_gap));
  endtask

  // Scoreboard: every strobe must match the oldest expected write.
  always @(negedge clock) begin
    logic [38:0] e;
    if (if0.mem_wr_en) begin
      if (exp_q0.size() == 0) chk("strobe0_unexpected", 64'd1, 64'd0);
      else begin
        e = exp_q0.pop_front();
        chk("strobe0", 64'({if0.mem_addr, if0.mem_data}), 64'(e));
      end
    end
    if (if1.mem_wr_en) begin
      if (exp_q1.size() == 0) chk("strobe1_unexpected", 64'd1, 64'd0);
      else begin
        e = exp_q1.pop_front();
        chk("strobe1", 64'({5'd0, if1.mem_addr, if1.mem_data}), 64'(e));
      end
    end
  end

  initial begin
    if0.start = 1'b0; if0.rx_done_tick = 1'b0; if0.rx_data = '0;
    if1.start = 1'b0; if1.rx_done_tick = 1'b0; if1.rx_data = '0;
    model_start(0);
    model_start(1);
    repeat (3) @(negedge clock);
    check_zero("rst0", if0.mem_wr_en, if0.mem_addr, if0.mem_data, 8'(if0.word_count),
               if0.finish_rcv, if0.overflow, if0.frame_err);
    check_zero("rst1", if1.mem_wr_en, 7'(if1.mem_addr), if1.mem_data, 8'(if1.word_count),
               if1.finish_rcv, if1.overflow, if1.frame_err);
    reset = 1'b1;
    @(negedge clock);

    // Big-endian packing and one-clock latency after the fourth byte.
    send(0, 8'h12, 1); send(0, 8'h34, 1); send(0, 8'h56, 1); send(0, 8'h78, 0);
    chk("be_wr_en", 64'(if0.mem_wr_en), 64'd1);
    chk("be_addr",  64'(if0.mem_addr),  64'd0);
    chk("be_data",  64'(if0.mem_data),  64'h12345678);
    @(negedge clock);
    chk("be_pulse", 64'(if0.mem_wr_en), 64'd0);
    chk("be_wc",    64'(if0.word_count), 64'd1);

    send(1, 8'h12, 1); send(1, 8'h34, 1); send(1, 8'h56, 1); send(1, 8'h78, 0);
    chk("le_wr_en", 64'(if1.mem_wr_en), 64'd1);
    chk("le_data",  64'(if1.mem_data),  64'h78563412);
    @(negedge clock);

    pulse_start(0);
    pulse_start(1);
    chk("start_wc0", 64'(if0.word_count), 64'd0);
    chk("start_wc1", 64'(if1.word_count), 64'd0);

    // Three random words then the halt word; later bytes must be ignored.
    for (int w = 0; w < 3; w++) send_word(0, 3);
    for (int k = 0; k < 4; k++) send(0, 8'hFF, $urandom_range(0, 3));
    repeat (2) @(negedge clock);
    chk("halt_fin", 64'(if0.finish_rcv), 64'd1);
    chk("halt_wc",  64'(if0.word_count), 64'd4);
    for (int k = 0; k < 6; k++) send(0, 8'($urandom_range(0, 255)), $urandom_range(0, 2));
    chk("halt_fin_hold", 64'(if0.finish_rcv), 64'(m_done[0]));
    chk("halt_ovf",      64'(if0.overflow),   64'd0);
    chk("halt_wc_hold",  64'(if0.word_count), 64'(m_cnt[0]));

    // Four-deep memory: fill it, then the next byte raises overflow.
    for (int w = 0; w < 3; w++) send_word(1, 3);
    repeat (2) @(negedge clock);
    chk("pre_full_fin", 64'(if1.finish_rcv), 64'd0);
    send_word(1, 3);
    repeat (2) @(negedge clock);
    chk("full_fin", 64'(if1.finish_rcv), 64'd1);
    chk("full_ovf", 64'(if1.overflow),   64'd0);
    chk("full_wc",  64'(if1.word_count), 64'd4);
    send(1, 8'($urandom_range(0, 255)), 2);
    chk("full_ovf_set", 64'(if1.overflow), 64'(m_ovf[1]));
    chk("full_ovf_one", 64'(if1.overflow), 64'd1);

    // Inter-byte timeout discards a two-byte partial word.
    pulse_start(0);
    send(0, 8'h11, 1);
    send(0, 8'h22, 0);
    m_n[0] = 0;
    for (int i = 1; i <= 25; i++) begin
      @(negedge clock);
      chk($sformatf("frame_err_%0d", i), 64'(if0.frame_err), 64'(i == 20));
    end
    send(0, 8'hAA, 1); send(0, 8'hBB, 1); send(0, 8'hCC, 1); send(0, 8'hDD, 0);
    chk("to_addr", 64'(if0.mem_addr), 64'd0);
    chk("to_data", 64'(if0.mem_data), 64'hAABBCCDD);
    @(negedge clock);

    // start coincident with the third byte wins.
    pulse_start(0);
    send(0, 8'h01, 1);
    send(0, 8'h02, 1);
    if0.start = 1'b1; if0.rx_done_tick = 1'b1; if0.rx_data = 8'h03;
    @(negedge clock);
    if0.start = 1'b0; if0.rx_done_tick = 1'b0;
    model_start(0);
    chk("coinc_wc", 64'(if0.word_count), 64'd0);
    send_word(0, 2);
    repeat (2) @(negedge clock);
    chk("coinc_wc_after", 64'(if0.word_count), 64'd1);

    // Reset while collecting.
    send(0, 8'h05, 1);
    send(0, 8'h06, 1);
    #2 reset = 1'b0;
    #1 check_zero("rstc0", if0.mem_wr_en, if0.mem_addr, if0.mem_data, 8'(if0.word_count),
                  if0.finish_rcv, if0.overflow, if0.frame_err);
    model_start(0);
    model_start(1);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    // Reset during the write cycle drops the strobe immediately.
    send(1, 8'h21, 1); send(1, 8'h43, 1); send(1, 8'h65, 1); send(1, 8'h87, 0);
    #2 reset = 1'b0;
    #1 check_zero("rstw1", if1.mem_wr_en, 7'(if1.mem_addr), if1.mem_data, 8'(if1.word_count),
                  if1.finish_rcv, if1.overflow, if1.frame_err);
    model_start(0);
    model_start(1);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    send_word(0, 3);
    send_word(1, 3);
    repeat (2) @(negedge clock);
    chk("post_rst_wc0", 64'(if0.word_count), 64'd1);
    chk("post_rst_wc1", 64'(if1.word_count), 64'd1);
    chk("q0_drained", 64'(exp_q0.size()), 64'd0);
    chk("q1_drained", 64'(exp_q1.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
